sccb_config_sequencer: RTL and testbench

- Upstream command source for the camera I2C/SCCB controller. Steps through a 16-bit register/value table in an external ROM and issues one write request per entry over a valid/ready handshake.
- Waits for each transaction to complete and retries failed writes. Before the first write it pulses the camera hardware reset and waits for power-up.
- Reports busy/done/error to the top-level capture pipeline, which stays idle until done_o is 1.

---
 rtl/sccb_config_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_sccb_config_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer: walks a ROM register table and issues SCCB writes, with camera reset/power-up and retries.
// Rev 1.0
`default_nettype none

module sccb_config_sequencer #(
  parameter logic [7:0] DEVICE_ADDR   = 8'h42,
  parameter int         NUM_REGS      = 128,
  parameter int         RESET_DELAY   = 1000,
  parameter int         POWERUP_DELAY = 100000,
  parameter int         DELAY_CYCLES  = 1000000,
  parameter int         MAX_RETRIES   = 3,
  localparam int        AW            = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  output logic [AW-1:0] rom_addr_o,
  input  logic [15:0]   rom_data_i,
  output logic          req_valid_o,
  input  logic          req_ready_i,
  output logic [7:0]    req_dev_addr_o,
  output logic [7:0]    req_reg_addr_o,
  output logic [7:0]    req_data_o,
  input  logic          ack_valid_i,
  input  logic          ack_error_i,
  output logic          reset_cmos_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [AW-1:0] reg_index_o
);

  localparam int MAXD_A = (RESET_DELAY > POWERUP_DELAY) ? RESET_DELAY : POWERUP_DELAY;
  localparam int MAXD   = (MAXD_A > DELAY_CYCLES) ? MAXD_A : DELAY_CYCLES;
  localparam int CW     = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int RW     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [15:0]   END_MARK  = 16'hFFFF;
  localparam logic [15:0]   DLY_MARK  = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMOS_RST,
    S_PWR_WAIT,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT_ACK,
    S_DELAY,
    S_DONE,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    val_q, val_d;
  logic          advance;

  // Counter terminates at zero, so loading N-1 gives exactly N cycles in state; N=0 behaves as 1.
  function automatic logic [CW-1:0] delay_load(input int n);
    return (n <= 1) ? '0 : CW'(n - 1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      dev_q   <= '0;
      reg_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    val_d   = val_q;
    advance = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          state_d = S_CMOS_RST;
          cnt_d   = delay_load(RESET_DELAY);
          idx_d   = '0;
          retry_d = '0;
        end
      end
      S_CMOS_RST: begin
        if (cnt_q == '0) begin
          state_d = S_PWR_WAIT;
          cnt_d   = delay_load(POWERUP_DELAY);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data_i == END_MARK) begin
          state_d = S_DONE;
        end else if (rom_data_i == DLY_MARK) begin
          state_d = S_DELAY;
          cnt_d   = delay_load(DELAY_CYCLES);
        end else begin
          state_d = S_SEND;
          dev_d   = DEVICE_ADDR;
          reg_d   = rom_data_i[15:8];
          val_d   = rom_data_i[7:0];
        end
      end
      S_SEND: begin
        if (req_ready_i) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_valid_i) begin
          if (!ack_error_i) begin
            retry_d = '0;
            advance = 1'b1;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_SEND;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // The last table slot ends the run even without an end marker; the index never wraps.
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + AW'(1);
        state_d = S_FETCH;
      end
    end
  end

  assign rom_addr_o     = idx_q;
  assign reg_index_o    = idx_q;
  assign req_valid_o    = (state_q == S_SEND);
  assign req_dev_addr_o = dev_q;
  assign req_reg_addr_o = reg_q;
  assign req_data_o     = val_q;
  assign reset_cmos_o   = (state_q != S_CMOS_RST);
  assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign done_o         = (state_q == S_DONE);
  assign error_o        = (state_q == S_FAIL);

endmodule

`default_nettype wire

// File: tb/tb_sccb_config_sequencer.sv
// tb_sccb_config_sequencer: table-driven runs with a request scoreboard, plus mid-run reset and spurious-ack sequence.
// Rev 1.0
`default_nettype none

module tb_sccb_config_sequencer;

  localparam int NREG = 4;
  localparam int MAXR = 2;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic        req_ready_i = 1'b0;
  logic        ack_valid_i = 1'b0;
  logic        ack_error_i = 1'b0;
  logic [15:0] rom_data_i;
  logic [1:0]  rom_addr_o, reg_index_o;
  logic        req_valid_o, reset_cmos_o, busy_o, done_o, error_o;
  logic [7:0]  req_dev_addr_o, req_reg_addr_o, req_data_o;
  logic [15:0] rom_mem [NREG];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data_i <= rom_mem[rom_addr_o];

  sccb_config_sequencer #(
    .DEVICE_ADDR  (8'h42),
    .NUM_REGS     (NREG),
    .RESET_DELAY  (4),
    .POWERUP_DELAY(8),
    .DELAY_CYCLES (5),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_dev_addr_o(req_dev_addr_o),
    .req_reg_addr_o(req_reg_addr_o),
    .req_data_o    (req_data_o),
    .ack_valid_i   (ack_valid_i),
    .ack_error_i   (ack_error_i),
    .reset_cmos_o  (reset_cmos_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .reg_index_o   (reg_index_o)
  );

  typedef struct {
    logic [3:0][15:0] rom;
    int               n_err;
    bit               all_err;
    int               hold;
    int               exp_reqs;
    bit               exp_done;
    bit               exp_err;
    int               exp_idx;
    int               exp_lat;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [23:0] exp_q [$];

  int          hold = 0, n_err = 0;
  bit          all_err = 0, spur_en = 0;
  int          vcnt = 0, ack_cnt = 0, ack_num = 0, xfers = 0;
  int          cmos_low = 0, cmos_low_last = 0, lat = 0, lat_last = 0;
  bit          prev_cmos = 1, counting = 0, stable_bad = 0;
  logic [23:0] snap = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3, input int ne, input bit ae,
                              input int hd, input int reqs, input bit dn, input bit er,
                              input int idx, input int lt);
    vec_t v;
    v.rom      = {w3, w2, w1, w0};
    v.n_err    = ne;
    v.all_err  = ae;
    v.hold     = hd;
    v.exp_reqs = reqs;
    v.exp_done = dn;
    v.exp_err  = er;
    v.exp_idx  = idx;
    v.exp_lat  = lt;
    return v;
  endfunction

  // Reference walk of the table: every attempted write is pushed in order.
  function automatic void build_exp(input vec_t v);
    int          errs;
    int          t;
    logic [15:0] w;
    errs = v.n_err;
    for (int i = 0; i < NREG; i++) begin
      w = v.rom[i];
      if (w == 16'hFFFF) return;
      if (w != 16'hFFF0) begin
        t = 0;
        while (1) begin
          exp_q.push_back({8'h42, w[15:8], w[7:0]});
          t++;
          if (v.all_err || errs > 0) begin
            errs--;
            if (t > MAXR) return;
          end else begin
            break;
          end
        end
      end
    end
  endfunction

  // Bus-side responder and monitor, evaluated once per falling edge.
  task automatic mon();
    logic [23:0] f;
    logic [23:0] e;
    if (!reset_i) begin
      req_ready_i = 0; ack_valid_i = 0; ack_error_i = 0;
      vcnt = 0; ack_cnt = 0; ack_num = 0; xfers = 0;
      cmos_low = 0; cmos_low_last = 0; lat = 0; lat_last = 0;
      prev_cmos = 1; counting = 0; stable_bad = 0;
      return;
    end
    ack_valid_i = 0;
    ack_error_i = 0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        ack_valid_i = 1;
        ack_error_i = all_err || (ack_num < n_err);
        ack_num++;
      end
    end
    if (!reset_cmos_o) begin
      cmos_low++;
    end else if (!prev_cmos) begin
      cmos_low_last = cmos_low;
      cmos_low = 0;
      counting = 1;
      lat = 0;
    end
    prev_cmos = reset_cmos_o;
    if (counting) begin
      if (req_valid_o) begin
        lat_last = lat;
        counting = 0;
      end else begin
        if (spur_en && lat == 8) begin
          ack_valid_i = 1;
          ack_error_i = 1;
        end
        lat++;
      end
    end
    req_ready_i = 0;
    f = {req_dev_addr_o, req_reg_addr_o, req_data_o};
    if (req_valid_o) begin
      if (vcnt == 0) snap = f;
      else if (f != snap) stable_bad = 1;
      if (vcnt >= hold) begin
        req_ready_i = 1;
        xfers++;
        vcnt = 0;
        ack_cnt = 3;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_req", 32'(f), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_req_fields", 32'(f), 32'(e));
        end
      end else begin
        vcnt++;
      end
    end else if (vcnt != 0) begin
      stable_bad = 1;
      vcnt = 0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
  endtask

  task automatic pulse_start();
    start_i = 1;
    cyc();
    start_i = 0;
  endtask

  task automatic wait_end(input string nm);
    int w;
    w = 0;
    while (!(done_o || error_o) && w < 3000) begin
      cyc();
      w++;
    end
    chk({nm, "_finished"}, 32'(done_o | error_o), 32'd1);
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < NREG; i++) rom_mem[i] = v.rom[i];
    hold = v.hold;
    n_err = v.n_err;
    all_err = v.all_err;
    spur_en = 0;
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    reset_i = 0;
    cyc();
    reset_i = 1;
    load(v);
    build_exp(v);
    pulse_start();
    chk({nm, "_cmos_low_at_start"}, 32'(reset_cmos_o), 32'd0);
    chk({nm, "_busy_at_start"}, 32'(busy_o), 32'd1);
    wait_end(nm);
    chk({nm, "_done"}, 32'(done_o), 32'(v.exp_done));
    chk({nm, "_error"}, 32'(error_o), 32'(v.exp_err));
    chk({nm, "_busy_end"}, 32'(busy_o), 32'd0);
    chk({nm, "_reg_index"}, 32'(reg_index_o), v.exp_idx);
    chk({nm, "_req_count"}, xfers, v.exp_reqs);
    chk({nm, "_sb_leftover"}, exp_q.size(), 0);
    chk({nm, "_cmos_rst_width"}, cmos_low_last, 4);
    chk({nm, "_first_req_latency"}, lat_last, v.exp_lat);
    chk({nm, "_req_stable"}, 32'(stable_bad), 32'd0);
    repeat (20) cyc();
    chk({nm, "_no_more_reqs"}, xfers, v.exp_reqs);
    chk({nm, "_valid_idle"}, 32'(req_valid_o), 32'd0);
    pulse_start();
    chk({nm, "_restart_done_clr"}, 32'(done_o), 32'd0);
    chk({nm, "_restart_err_clr"}, 32'(error_o), 32'd0);
    chk({nm, "_restart_cmos_low"}, 32'(reset_cmos_o), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    string names[5];
    int w;
    vecs[0] = mk(16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 0, 0, 0,  2, 1, 0, 2, 10);
    vecs[1] = mk(16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 0, 0, 10, 2, 1, 0, 2, 10);
    vecs[2] = mk(16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 2, 0, 0,  4, 1, 0, 2, 10);
    vecs[3] = mk(16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 0, 1, 0,  3, 0, 1, 0, 10);
    vecs[4] = mk(16'hFFF0, 16'h3A04, 16'h1111, 16'h2222, 0, 0, 0,  3, 1, 0, 3, 17);
    names = '{"basic", "backpressure", "retry", "fail", "delay_boundary"};
    for (int i = 0; i < NREG; i++) rom_mem[i] = 16'h0000;

    cyc();
    cyc();
    chk("rst_valid", 32'(req_valid_o), 32'd0);
    chk("rst_cmos", 32'(reset_cmos_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done_err", 32'({done_o, error_o}), 32'd0);
    chk("rst_fields", 32'({req_dev_addr_o, req_reg_addr_o, req_data_o}), 32'd0);
    chk("rst_index", 32'({rom_addr_o, reg_index_o}), 32'd0);
    reset_i = 1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], names[i]);

    // Reset while waiting for an ack, then restart with a spurious ack during the first fetch.
    reset_i = 0;
    cyc();
    reset_i = 1;
    load(vecs[0]);
    exp_q.push_back({8'h42, 8'h12, 8'h80});
    pulse_start();
    w = 0;
    while (xfers < 1 && w < 200) begin
      cyc();
      w++;
    end
    chk("mr_first_xfer", xfers, 1);
    cyc();
    reset_i = 0;
    cyc();
    reset_i = 1;
    chk("mr_valid", 32'(req_valid_o), 32'd0);
    chk("mr_cmos", 32'(reset_cmos_o), 32'd1);
    chk("mr_busy_done_err", 32'({busy_o, done_o, error_o}), 32'd0);
    chk("mr_fields", 32'({req_dev_addr_o, req_reg_addr_o, req_data_o}), 32'd0);
    chk("mr_index", 32'({rom_addr_o, reg_index_o}), 32'd0);
    cyc();
    chk("mr_stays_idle", 32'({busy_o, reset_cmos_o}), 32'b01);
    load(vecs[0]);
    build_exp(vecs[0]);
    spur_en = 1;
    pulse_start();
    chk("mr_restart_cmos", 32'(reset_cmos_o), 32'd0);
    chk("mr_restart_busy", 32'(busy_o), 32'd1);
    wait_end("mr");
    chk("mr_done", 32'({done_o, error_o}), 32'b10);
    chk("mr_req_count", xfers, 2);
    chk("mr_sb_leftover", exp_q.size(), 0);
    chk("mr_latency", lat_last, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
